// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: data width, canonical NOP encoding and
// the fetch-stage FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

  // Instruction addresses are always word aligned; low bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry instruction/PC store that parks an in-flight fetch response
// while the front end is stalled.
module fetch_hold_buffer
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            release_en,
  input  logic            flush,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            full,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // release is a reserved word, hence release_en; flush beats load beats release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (release_en) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: PC, 1-cycle imem interface, IF/ID register
// and stall hold buffer. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hazard_fe_enable,
  input  logic            hazard_if_id_clear,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic            if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_redirects
`endif
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            rsp_valid_q;
  logic [XLEN-1:0] rsp_pc_q;
  logic [XLEN-1:0] redirect_target;

  fetch_state_t    state;
  fetch_state_t    state_next;

  logic            hold_load;
  logic            hold_release;
  logic            hold_flush;
  logic            hold_full;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;

  logic            if_id_load;
  logic [XLEN-1:0] if_id_instr_d;
  logic [XLEN-1:0] if_id_pc_d;
  logic            if_id_valid_d;

  // No request in a redirect cycle: pc_q still points down the wrong path.
  assign imem_req        = hazard_fe_enable && !redirect_valid;
  assign imem_addr       = pc_q;
  assign redirect_target = align_pc(redirect_pc);
  assign if_id_pc_plus4  = if_id_pc + 32'd4;

  fetch_hold_buffer u_hold_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (hold_load),
    .release_en (hold_release),
    .flush      (hold_flush),
    .load_instr (imem_rdata),
    .load_pc    (rsp_pc_q),
    .full       (hold_full),
    .instr      (hold_instr),
    .pc         (hold_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      rsp_valid_q <= imem_req;
      if (imem_req) begin
        rsp_pc_q <= pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN:     if (!hazard_fe_enable && rsp_valid_q) state_next = HOLD;
        HOLD:    if (hazard_fe_enable) state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  // A clear only overrides what IF/ID loads; PC and hold buffer still follow
  // the stall/advance rules so the fetch stream stays consistent.
  always_comb begin
    pc_d          = pc_q;
    if_id_load    = 1'b0;
    if_id_instr_d = NOP_INSTR;
    if_id_pc_d    = '0;
    if_id_valid_d = 1'b0;
    hold_load     = 1'b0;
    hold_release  = 1'b0;
    hold_flush    = 1'b0;

    if (redirect_valid) begin
      pc_d       = redirect_target;
      if_id_load = 1'b1;
      hold_flush = 1'b1;
    end else begin
      if (hazard_fe_enable) begin
        pc_d = pc_q + 32'd4;
      end

      case (state)
        RUN: begin
          if (hazard_fe_enable) begin
            if_id_load    = 1'b1;
            if_id_instr_d = imem_rdata;
            if_id_pc_d    = rsp_pc_q;
            if_id_valid_d = rsp_valid_q;
          end else if (rsp_valid_q) begin
            hold_load = 1'b1;
          end
        end
        HOLD: begin
          if (hazard_fe_enable) begin
            if_id_load    = 1'b1;
            if_id_instr_d = hold_instr;
            if_id_pc_d    = hold_pc;
            if_id_valid_d = hold_full;
            hold_release  = 1'b1;
          end
        end
        default: ;
      endcase

      if (hazard_if_id_clear) begin
        if_id_load    = 1'b1;
        if_id_instr_d = NOP_INSTR;
        if_id_pc_d    = '0;
        if_id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else if (if_id_load) begin
      if_id_instr <= if_id_instr_d;
      if_id_pc    <= if_id_pc_d;
      if_id_valid <= if_id_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (!hazard_fe_enable && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (redirect_valid && (perf_redirects != 32'hFFFF_FFFF)) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a queue-based fetch-stream model predicts
// which PCs reach IF/ID; a monitor pops and compares each delivered instruction.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] WRAP_RESET_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hazard_fe_enable;
  logic        hazard_if_id_clear;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic        w_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_redirects;
  logic [31:0] w_perf_stall_cycles;
  logic [31:0] w_perf_redirects;
`endif

  int          checks = 0;
  int          errors = 0;

  exp_t        exp_q[$];
  logic [31:0] m_avail[$];
  logic [31:0] m_next_pc;
  int          m_stalls;
  int          m_redirects;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .hazard_fe_enable   (hazard_fe_enable),
    .hazard_if_id_clear (hazard_if_id_clear),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_rdata         (imem_rdata),
    .if_id_instr        (if_id_instr),
    .if_id_pc           (if_id_pc),
    .if_id_pc_plus4     (if_id_pc_plus4),
    .if_id_valid        (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_redirects     (perf_redirects)
`endif
  );

  fetch_stage #(.RESET_PC(WRAP_RESET_PC)) dut_wrap (
    .clk                (clk),
    .rst_n              (rst_n),
    .hazard_fe_enable   (1'b1),
    .hazard_if_id_clear (1'b0),
    .redirect_valid     (1'b0),
    .redirect_pc        (32'h0000_0000),
    .imem_req           (w_imem_req),
    .imem_addr          (w_imem_addr),
    .imem_rdata         (w_imem_rdata),
    .if_id_instr        (w_instr),
    .if_id_pc           (w_pc),
    .if_id_pc_plus4     (w_pc_plus4),
    .if_id_valid        (w_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles  (w_perf_stall_cycles),
    .perf_redirects     (w_perf_redirects)
`endif
  );

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return 32'h1000_0000 + addr;
  endfunction

  // Unrequested cycles return garbage so stale reads are caught.
  always @(posedge clk) begin
    imem_rdata   <= imem_req ? instr_of(imem_addr) : $urandom();
    w_imem_rdata <= w_imem_req ? instr_of(w_imem_addr) : $urandom();
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Fetch stream model: fetched-but-undelivered PCs wait in m_avail and are
  // handed to ID in order on enabled cycles; clears squash, redirects restart.
  task automatic model_step(input logic en, input logic clr, input logic redir,
                            input logic [31:0] rpc);
    logic [31:0] pc;
    if (!en) m_stalls++;
    if (redir) begin
      m_redirects++;
      m_avail.delete();
      m_next_pc = rpc & ~32'h3;
    end else if (en) begin
      if (m_avail.size() > 0) begin
        pc = m_avail.pop_front();
        if (!clr) exp_q.push_back('{pc: pc, instr: instr_of(pc)});
      end
      m_avail.push_back(m_next_pc);
      m_next_pc = m_next_pc + 32'd4;
    end
  endtask

  task automatic drive_cycle(input logic en, input logic clr, input logic redir,
                             input logic [31:0] rpc);
    hazard_fe_enable   = en;
    hazard_if_id_clear = clr;
    redirect_valid     = redir;
    redirect_pc        = rpc;
    #1;
    check_output("imem_req", {31'd0, imem_req}, {31'd0, en && !redir});
    if (en && !redir) check_output("imem_addr", imem_addr, m_next_pc);
`ifdef FETCH_PERF_CNT_EN
    check_output("perf_stall_cycles", perf_stall_cycles, m_stalls);
    check_output("perf_redirects", perf_redirects, m_redirects);
`endif
    model_step(en, clr, redir, rpc);
  endtask

  task automatic apply_stimulus(input logic en, input logic clr, input logic redir,
                                input logic [31:0] rpc);
    @(negedge clk);
    drive_cycle(en, clr, redir, rpc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n              = 1'b0;
    hazard_fe_enable   = 1'b1;
    hazard_if_id_clear = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    #1;
    check_output("undelivered_at_reset", exp_q.size(), 0);
    exp_q.delete();
    m_avail.delete();
    m_next_pc   = 32'h0000_0000;
    m_stalls    = 0;
    m_redirects = 0;
    check_output("reset_valid", {31'd0, if_id_valid}, 32'd0);
    check_output("reset_instr", if_id_instr, NOP_INSTR);
    check_output("reset_pc", if_id_pc, 32'd0);
    check_output("reset_imem_req", {31'd0, imem_req}, 32'd1);
    check_output("reset_imem_addr", imem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  // Monitor: inputs are captured at the edge, outputs sampled 1ns later.
  initial begin
    logic        s_rst, s_en, s_clr, s_redir;
    logic [31:0] prev_pc, prev_instr;
    logic        prev_valid;
    exp_t        e;
    prev_pc    = '0;
    prev_instr = NOP_INSTR;
    prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      s_rst   = rst_n;
      s_en    = hazard_fe_enable;
      s_clr   = hazard_if_id_clear;
      s_redir = redirect_valid;
      #1;
      if (s_rst && rst_n) begin
        if (s_redir || s_clr) begin
          check_output("squash_valid", {31'd0, if_id_valid}, 32'd0);
          check_output("squash_instr", if_id_instr, NOP_INSTR);
        end else if (!s_en) begin
          check_output("stall_hold_pc", if_id_pc, prev_pc);
          check_output("stall_hold_instr", if_id_instr, prev_instr);
          check_output("stall_hold_valid", {31'd0, if_id_valid}, {31'd0, prev_valid});
        end else if (if_id_valid) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_delivery_pc", if_id_pc, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            check_output("if_id_pc", if_id_pc, e.pc);
            check_output("if_id_instr", if_id_instr, e.instr);
            check_output("if_id_pc_plus4", if_id_pc_plus4, e.pc + 32'd4);
          end
        end
      end
      prev_pc    = if_id_pc;
      prev_instr = if_id_instr;
      prev_valid = if_id_valid;
    end
  end

  // Wrap-around instance: first three deliveries after the first reset release.
  initial begin
    logic [31:0] exp_pcs[3];
    int          got;
    exp_pcs[0] = 32'hFFFF_FFF8;
    exp_pcs[1] = 32'hFFFF_FFFC;
    exp_pcs[2] = 32'h0000_0000;
    got = 0;
    @(posedge rst_n);
    for (int c = 0; c < 8 && got < 3; c++) begin
      @(posedge clk);
      #1;
      if (w_valid) begin
        check_output("wrap_pc", w_pc, exp_pcs[got]);
        check_output("wrap_pc_plus4", w_pc_plus4, exp_pcs[got] + 32'd4);
        check_output("wrap_instr", w_instr, instr_of(exp_pcs[got]));
        got++;
      end
    end
    check_output("wrap_deliveries", got, 3);
  end

  initial begin
    logic        en, clr, redir;
    logic [31:0] rpc;
    rst_n              = 1'b0;
    hazard_fe_enable   = 1'b1;
    hazard_if_id_clear = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    m_next_pc          = '0;
    m_stalls           = 0;
    m_redirects        = 0;

    $display("[TB] straight-line fetch with a single-cycle stall");
    do_reset();
    repeat (2) apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0);
    repeat (4) apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0);

    $display("[TB] five-cycle stall");
    repeat (5) apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0);
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0);

    $display("[TB] redirect while holding");
    repeat (2) apply_stimulus(1'b0, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000_0203);
    repeat (4) apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0);

    $display("[TB] clear with stall, then jump");
    repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0000_0400);
    repeat (4) apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 9) == 0);
      redir = ($urandom_range(0, 12) == 0);
      rpc   = ($urandom_range(0, 1) == 0) ? ($urandom() & 32'h0000_0FFF)
                                          : (32'hFFFF_FFF0 | ($urandom() & 32'hF));
      if ($urandom_range(0, 599) == 0) do_reset();
      else apply_stimulus(en, clr, redir, rpc);
    end

    repeat (4) apply_stimulus(1'b1, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    check_output("undelivered_at_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 5-stage RV32I pipeline. It owns the PC, drives a synchronous 1-cycle-latency instruction memory, and holds the IF/ID pipeline register. It obeys the hazard unit's front-end enable and IF/ID clear, and accepts branch/jump redirects resolved in EX. A one-entry hold buffer keeps an in-flight instruction from being lost while the front end is stalled.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  input  1  pipeline clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- hazard_fe_enable  input  1  1 = front end may advance; 0 = hold PC and IF/ID.
- hazard_if_id_clear  input  1  squash IF/ID contents.
- redirect_valid  input  1  EX resolved a taken branch or jump this cycle.
- redirect_pc  input  32  target address; bits [1:0] ignored and treated as 0.
- imem_req  output  1  read strobe for imem_addr.
- imem_addr  output  32  fetch address, equal to pc_q.
- imem_rdata  input  32  instruction for the address requested in the previous cycle.
- if_id_instr  output  32  instruction to ID.
- if_id_pc  output  32  PC of if_id_instr.
- if_id_pc_plus4  output  32  if_id_pc + 4, modulo 2^32.
- if_id_valid  output  1  IF/ID holds a real instruction.
- perf_stall_cycles, perf_redirects  output  32 each  present only with FETCH_PERF_CNT_EN.

## Operation
- Internal registers:
  - pc_q: next address to request.
  - rsp_valid_q and rsp_pc_q: the response expected on imem_rdata this cycle.
  - state: RUN or HOLD.
  - hold_instr_q and hold_pc_q: the hold buffer.
- imem_req = hazard_fe_enable && !redirect_valid. imem_addr = pc_q.
- Every cycle: rsp_valid_q <= imem_req. On imem_req, rsp_pc_q <= pc_q.
- Priority per cycle: redirect > if_id_clear > stall > advance.
- Redirect:
  - pc_q <= {redirect_pc[31:2], 2'b00}. rsp_valid_q <= 0.
  - Hold buffer is discarded. state <= RUN.
  - IF/ID loads NOP (32'h0000_0013) with valid = 0.
- if_id_clear (no redirect):
  - IF/ID loads NOP with valid = 0.
  - PC and state follow the stall/advance rules.
- RUN, hazard_fe_enable = 1:
  - pc_q <= pc_q + 4.
  - IF/ID loads {imem_rdata, rsp_pc_q}, with valid = rsp_valid_q.
- RUN, hazard_fe_enable = 0:
  - pc_q and IF/ID hold.
  - If rsp_valid_q: hold_instr_q <= imem_rdata, hold_pc_q <= rsp_pc_q, state <= HOLD.
- HOLD, hazard_fe_enable = 0: everything holds.
- HOLD, hazard_fe_enable = 1:
  - IF/ID loads {hold_instr_q, hold_pc_q}, valid = 1.
  - pc_q <= pc_q + 4. state <= RUN.
- When a clear coincides with a HOLD release, the clear wins for IF/ID; the held instruction is dropped and state still goes to RUN.
- All PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values (asynchronous):
  - pc_q = RESET_PC, rsp_valid_q = 0, state = RUN.
  - if_id_instr = NOP, if_id_pc = 0, if_id_valid = 0.
  - Perf counters = 0.
  - imem_req follows its combinational equation.
- Fetch latency: address in cycle N, instruction visible on if_id_* after the edge ending cycle N+1.
- First valid IF/ID: 2 cycles after reset release, with hazard_fe_enable held high.
- Redirect penalty: 2 bubble cycles. No request is issued in the redirect cycle; the target is requested in the next cycle.
- Reset asserted mid-stall or mid-HOLD drops the buffered instruction; restart is at RESET_PC.
- No instruction is lost or duplicated across any stall length, including single-cycle stalls.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - perf_stall_cycles increments on every cycle with hazard_fe_enable = 0.
  - perf_redirects increments on every cycle with redirect_valid = 1.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the perf ports and counters do not exist.

## Structure
- Shared package riscv_pkg holds NOP_INSTR, the fetch_state_t enum (RUN, HOLD) and XLEN = 32.
- Sub-module fetch_hold_buffer holds the one-entry instruction/PC storage:
  - Inputs: load, release, flush.
  - Outputs: full, instr, pc.

## Test plan
- Reset release, enable held high, imem returns 32'h1000_0000 + addr → IF/ID shows PCs 0, 4, 8 on consecutive cycles starting cycle 2, valid = 1.
- Single-cycle stall while the instruction for PC 8 is in flight → PC 8 appears exactly once, on the cycle after the stall, followed by PC 12.
- 5-cycle stall → state = HOLD for 5 cycles, imem_req = 0 throughout, the held PC issues on release, and perf_stall_cycles = 5.
- redirect_valid with redirect_pc = 32'h0000_0203 during HOLD → next request is to 0x200, the hold buffer is discarded, and two valid = 0 bubbles precede PC 0x200.
- hazard_if_id_clear together with enable = 0 for 3 cycles (jump in ID), then a redirect → IF/ID shows NOP/valid = 0, no stale instruction leaks through, and the target is fetched.
- RESET_PC = 32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; if_id_pc_plus4 for FFFF_FFFC is 0.
